uart_rx_fifo: RTL and testbench
===============================

// Module: uart_rx_fifo
// PURPOSE
//  Oversampling UART receiver with glitch rejection, framing check and a byte FIFO.
//  Sits directly upstream of the PWM command decoder and replaces its inline RX state machine.
//  Presents received bytes on a valid/ready stream, so command bursts are not lost while the decoder is busy.
// PARAMETERS
//  CLK_FREQ    12000000  system clock in Hz
//  BAUD_RATE   115200    line rate in baud
//  OVERSAMPLE  8         sample ticks per bit; even, >=4
//  FIFO_DEPTH  8         byte entries; power of 2, >=2
//  TICK_DIV    CLK_FREQ/(BAUD_RATE*OVERSAMPLE), rounded to nearest; 13 by default, giving 104 clk/bit
// PORTS
//  clk         in   1   system clock
//  rst_n       in   1   asynchronous reset, active-low
//  rx          in   1   raw UART line, idle high
//  m_data      out  8   byte at the FIFO head
//  m_valid     out  1   FIFO not empty
//  m_ready     in   1   consumer accepts m_data when m_valid && m_ready
//  frame_err   out  1   1-cycle pulse: stop bit sampled 0
//  parity_err  out  1   1-cycle pulse: parity mismatch; tied 0 without UART_RX_PARITY_EN
//  overrun     out  1   1-cycle pulse: byte completed while FIFO full and no pop that cycle
//  fifo_level  out  $clog2(FIFO_DEPTH)+1   current occupancy
// BEHAVIOUR
//  Reset values: m_data=0, m_valid=0, all error pulses 0, fifo_level=0.
//  Reset state: FSM in IDLE, both sync flops 1, tick and bit counters 0.
//  Reset is asynchronous. Asserting it mid-frame abandons the frame with no push.
//  rx passes through a 2-FF synchronizer. All references to rx below mean the synced value.
//  Tick generator: a counter wraps at TICK_DIV-1 and emits a tick, running only outside IDLE.
//  The tick counter and the sample counter s (0..OVERSAMPLE-1) are cleared on leaving IDLE.
//  Bit value: majority of the samples taken at ticks s = OS/2-1, OS/2, OS/2+1.
//  The decision is made at the tick s=OS/2+1.
//  FSM states and transitions:
//   IDLE:   rx=0 -> START.
//   START:  majority low -> DATA at end of bit; majority high -> IDLE (glitch rejected).
//   DATA:   8 bits, LSB first, into a shift register -> PARITY (if enabled) or STOP.
//   PARITY: even parity over data+parity bit; mismatch sets a flag -> STOP.
//   STOP:   at decision tick: 1 -> push byte (unless parity flag), return to IDLE immediately.
//           0 -> frame_err pulse, no push -> BREAK.
//   BREAK:  waits for rx=1 -> IDLE. No new start is detected while rx is held low.
//  Latency: the byte is written on the STOP decision clock; m_valid/m_data update the next clock.
//  FIFO is first-word fall-through: m_data always shows the head entry; pop on m_valid&&m_ready.
//  Full with push and pop in the same cycle: both happen, level unchanged, no overrun.
//  Full with push and no pop: byte dropped, overrun pulse, FIFO contents untouched.
//  Empty: m_ready is ignored and m_data holds its last value.
//  Read/write pointers are $clog2(FIFO_DEPTH) bits and wrap naturally.
//  Level counts 0..FIFO_DEPTH.
// CONFIGURATION
//  UART_RX_PARITY_EN defined:
//   the frame carries one even-parity bit after D7 (11 bit-times per frame);
//   a mismatched byte is dropped and parity_err pulses at the STOP decision tick;
//   a framing error takes priority, so only frame_err pulses.
//  UART_RX_PARITY_EN undefined: 8N1 framing, PARITY state absent, parity_err constant 0.
// STRUCTURE
//  Package uart_pkg holds:
//   FSM state localparams (IDLE, START, DATA, PARITY, STOP, BREAK, 3-bit encoding);
//   the TICK_DIV computation function;
//   the ACK constants 8'h55/8'hAA shared with the command decoder.
//  Sub-module sync_fifo (WIDTH, DEPTH; push/pop/full/empty/level, FWFT) holds the storage.
//  The receiver FSM, synchronizer and tick generator stay in uart_rx_fifo.
// TESTING
//  Bench at 12 MHz drives frames at 104 clk/bit (8N1) unless noted.
//  1 Bytes 0x01, 0x80 with m_ready=1 -> m_data 0x01 then 0x80, one m_valid beat each, no error pulses.
//  2 rx low for 20 clk, then high -> START rejects it, no push, FSM back in IDLE, fifo_level stays 0.
//  3 Byte 0x55 with stop bit forced 0 for 2 bit-times -> one frame_err pulse, no push;
//    next 0xA3 is received correctly.
//  4 m_ready=0, bytes 0x10..0x18 -> fifo_level reaches 8, overrun pulses on 0x18;
//    the drain then yields 0x10..0x17 in order.
//  5 rst_n low for 3 clk during data bit 4 of 0x3C -> outputs at reset values, no push;
//    next byte 0xC3 is received correctly.
//  6 UART_RX_PARITY_EN defined: 0x03 with parity 0 -> pushed;
//    0x03 with parity 1 -> parity_err pulse, no push.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states, tick divider, ACK bytes.
// Used by uart_rx_fifo and the PWM command decoder.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4,
        BREAK  = 3'd5
    } state_t;

    localparam logic [7:0] ACK_OK  = 8'h55;
    localparam logic [7:0] ACK_ERR = 8'hAA;

    // Clocks per sample tick, rounded to nearest.
    function automatic int calc_tick_div(int clk_freq, int baud, int os);
        return (clk_freq + (baud * os) / 2) / (baud * os);
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// First-word fall-through FIFO with registered head output.
// Push while full without a pop is dropped and flagged on drop.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [WIDTH-1:0]           din,
    input  logic                       pop,
    output logic [WIDTH-1:0]           dout,
    output logic                       full,
    output logic                       empty,
    output logic                       drop,
    output logic [$clog2(DEPTH):0]     level
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LVL = DEPTH[AW:0];

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    nxt_rd;
    logic [AW:0]      nxt_lvl;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (level == FULL_LVL);
    assign empty   = (level == '0);
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);
    assign drop    = push && !push_ok;
    assign nxt_rd  = pop_ok ? rd_ptr + AW'(1) : rd_ptr;

    // Next occupancy from the accepted push/pop pair.
    always_comb begin
        nxt_lvl = level;
        case ({push_ok, pop_ok})
            2'b10:   nxt_lvl = level + (AW+1)'(1);
            2'b01:   nxt_lvl = level - (AW+1)'(1);
            default: nxt_lvl = level;
        endcase
    end

    // Storage write; no reset needed for the array.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= din;
    end

    // Pointers, level and head register; head holds when empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            dout   <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            rd_ptr <= nxt_rd;
            level  <= nxt_lvl;
            if (nxt_lvl != '0) begin
                if (push_ok && (wr_ptr == nxt_rd)) dout <= din;
                else                               dout <= mem[nxt_rd];
            end
        end
    end

endmodule

// File: rtl/uart_rx_fifo.sv
// Oversampling UART receiver with majority voting and a byte FIFO.
// Define UART_RX_PARITY_EN for 8E1 framing; default is 8N1.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 12000000,
    parameter int BAUD_RATE  = 115200,
    parameter int OVERSAMPLE = 8,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          rx,
    output logic [7:0]                    m_data,
    output logic                          m_valid,
    input  logic                          m_ready,
    output logic                          frame_err,
    output logic                          parity_err,
    output logic                          overrun,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int TICK_DIV = calc_tick_div(CLK_FREQ, BAUD_RATE, OVERSAMPLE);
    localparam int TW = $clog2(TICK_DIV);
    localparam int SW = $clog2(OVERSAMPLE);
    localparam logic [TW-1:0] TICK_MAX = TW'(TICK_DIV - 1);
    localparam logic [SW-1:0] S_LO  = SW'(OVERSAMPLE / 2 - 1);
    localparam logic [SW-1:0] S_MID = SW'(OVERSAMPLE / 2);
    localparam logic [SW-1:0] S_HI  = SW'(OVERSAMPLE / 2 + 1);
    localparam logic [SW-1:0] S_END = SW'(OVERSAMPLE - 1);

    state_t        state;
    state_t        state_nxt;
    logic          rx_meta;
    logic          rx_s;
    logic [TW-1:0] tick_cnt;
    logic [SW-1:0] s_cnt;
    logic [2:0]    bit_cnt;
    logic [1:0]    smp;
    logic [7:0]    shreg;
    logic          tick;
    logic          decide;
    logic          bit_end;
    logic          maj;
    logic          push;
    logic          fifo_full;
    logic          fifo_empty;
    logic          par_flag;

    assign tick    = (state != IDLE) && (tick_cnt == TICK_MAX);
    assign decide  = tick && (s_cnt == S_HI);
    assign bit_end = tick && (s_cnt == S_END);
    assign maj     = (smp[0] & smp[1]) | (smp[0] & rx_s) | (smp[1] & rx_s);
    assign m_valid = !fifo_empty;

    // Two-flop synchronizer, idle-high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end

    // Tick and sample counters, held at zero while idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_cnt <= '0;
            s_cnt    <= '0;
        end else if (state == IDLE) begin
            tick_cnt <= '0;
            s_cnt    <= '0;
        end else if (tick) begin
            tick_cnt <= '0;
            s_cnt    <= (s_cnt == S_END) ? '0 : s_cnt + SW'(1);
        end else begin
            tick_cnt <= tick_cnt + TW'(1);
        end
    end

    // Mid-bit samples, data shift register and bit count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            smp     <= 2'b11;
            shreg   <= '0;
            bit_cnt <= '0;
        end else begin
            if (tick && (s_cnt == S_LO))  smp[0] <= rx_s;
            if (tick && (s_cnt == S_MID)) smp[1] <= rx_s;
            if (decide && (state == DATA)) shreg <= {maj, shreg[7:1]};
            if (state == IDLE) bit_cnt <= '0;
            else if (bit_end && (state == DATA)) bit_cnt <= bit_cnt + 3'd1;
        end
    end

`ifdef UART_RX_PARITY_EN
    // Latch an even-parity mismatch for the stop-bit decision.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) par_flag <= 1'b0;
        else if (state == IDLE) par_flag <= 1'b0;
        else if (decide && (state == PARITY)) par_flag <= ^{shreg, maj};
    end
`else
    assign par_flag = 1'b0;
`endif

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next state, push strobe and error pulses.
    always_comb begin
        state_nxt  = state;
        push       = 1'b0;
        frame_err  = 1'b0;
        parity_err = 1'b0;
        unique case (state)
            IDLE:  if (!rx_s) state_nxt = START;
            START: begin
                if (decide && maj) state_nxt = IDLE;
                else if (bit_end)  state_nxt = DATA;
            end
            DATA: begin
                if (bit_end && (bit_cnt == 3'd7)) begin
`ifdef UART_RX_PARITY_EN
                    state_nxt = PARITY;
`else
                    state_nxt = STOP;
`endif
                end
            end
            PARITY: if (bit_end) state_nxt = STOP;
            STOP: begin
                if (decide) begin
                    if (maj) begin
                        state_nxt = IDLE;
                        if (par_flag) parity_err = 1'b1;
                        else          push       = 1'b1;
                    end else begin
                        frame_err = 1'b1;
                        state_nxt = BREAK;
                    end
                end
            end
            BREAK:   if (rx_s) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .din   (shreg),
        .pop   (m_ready),
        .dout  (m_data),
        .full  (fifo_full),
        .empty (fifo_empty),
        .drop  (overrun),
        .level (fifo_level)
    );

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: directed frames plus random bytes vs a queue model.
// Parity frames are exercised when UART_RX_PARITY_EN is defined.
`timescale 1ns/1ps
module tb_uart_rx_fifo;

    localparam int BITC  = 104;
    localparam int DEPTH = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx = 1'b1;
    logic       m_ready = 1'b0;
    logic [7:0] m_data;
    logic       m_valid;
    logic       frame_err;
    logic       parity_err;
    logic       overrun;
    logic [3:0] fifo_level;

    int checks = 0;
    int errors = 0;
    int n_pop  = 0;
    int n_ferr = 0;
    int n_perr = 0;
    int n_ovr  = 0;
    int exp_ovr = 0;
    int exp_pop = 0;
    logic [7:0] q[$];

    uart_rx_fifo dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx         (rx),
        .m_data     (m_data),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .frame_err  (frame_err),
        .parity_err (parity_err),
        .overrun    (overrun),
        .fifo_level (fifo_level)
    );

    always #41.667 clk = ~clk;

    // Monitor: score every accepted beat and count error pulses.
    always @(negedge clk) begin
        if (rst_n) begin
            if (frame_err)  n_ferr++;
            if (parity_err) n_perr++;
            if (overrun)    n_ovr++;
            if (m_valid && m_ready) begin
                logic [7:0] e;
                e = 8'hxx;
                if (q.size() != 0) e = q.pop_front();
                checks++;
                n_pop++;
                assert (m_data === e) else begin
                    errors++;
                    $error("FAIL pop_data got %h exp %h", m_data, e);
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s got %0h exp %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive_bit(input logic v, input int n);
        rx = v;
        wait_clk(n);
    endtask

    task automatic send(input logic [7:0] b, input logic par_bad,
                        input logic stop_v);
        drive_bit(1'b0, BITC);
        for (int i = 0; i < 8; i++) drive_bit(b[i], BITC);
`ifdef UART_RX_PARITY_EN
        drive_bit((^b) ^ par_bad, BITC);
`endif
        if (stop_v) begin
            drive_bit(1'b1, BITC);
        end else begin
            drive_bit(1'b0, 2 * BITC);
            drive_bit(1'b1, BITC);
        end
    endtask

    // Model: a good frame enters the FIFO unless it is already full.
    task automatic send_good(input logic [7:0] b);
        if (q.size() < DEPTH) begin
            q.push_back(b);
            if (m_ready) exp_pop++;
        end else begin
            exp_ovr++;
        end
        send(b, 1'b0, 1'b1);
    endtask

    initial begin
        int k;
        logic [7:0] b;
        logic [7:0] b3c;

        wait_clk(5);
        chk("rst_valid", m_valid, 0);
        chk("rst_data", m_data, 0);
        chk("rst_level", fifo_level, 0);
        chk("rst_ferr", frame_err, 0);
        chk("rst_perr", parity_err, 0);
        chk("rst_ovr", overrun, 0);
        rst_n = 1'b1;
        wait_clk(5);

        m_ready = 1'b1;
        send_good(8'h01);
        send_good(8'h80);
        wait_clk(BITC);
        chk("t1_pops", n_pop, exp_pop);
        chk("t1_level", fifo_level, 0);
        chk("t1_ferr", n_ferr, 0);
        chk("t1_ovr", n_ovr, 0);

        rx = 1'b0;
        wait_clk(20);
        rx = 1'b1;
        wait_clk(3 * BITC);
        chk("t2_level", fifo_level, 0);
        chk("t2_pops", n_pop, exp_pop);
        chk("t2_ferr", n_ferr, 0);
        send_good(8'h5A);
        wait_clk(BITC);
        chk("t2_after", n_pop, exp_pop);

        send(8'h55, 1'b0, 1'b0);
        wait_clk(BITC);
        chk("t3_ferr", n_ferr, 1);
        chk("t3_level", fifo_level, 0);
        chk("t3_pops", n_pop, exp_pop);
        send_good(8'hA3);
        wait_clk(BITC);
        chk("t3_after", n_pop, exp_pop);

        m_ready = 1'b0;
        for (int i = 0; i < 9; i++) send_good(8'h10 + 8'(i));
        wait_clk(BITC);
        chk("t4_level", fifo_level, q.size());
        chk("t4_full", fifo_level, DEPTH);
        chk("t4_ovr", n_ovr, exp_ovr);
        chk("t4_valid", m_valid, 1);
        chk("t4_head", m_data, 8'h10);
        m_ready = 1'b1;
        exp_pop += q.size();
        wait_clk(20);
        chk("t4_drain", fifo_level, 0);
        chk("t4_pops", n_pop, exp_pop);
        chk("t4_qempty", q.size(), 0);

        b3c = 8'h3C;
        drive_bit(1'b0, BITC);
        for (int i = 0; i < 4; i++) drive_bit(b3c[i], BITC);
        rx = b3c[4];
        wait_clk(BITC / 2);
        rst_n = 1'b0;
        wait_clk(3);
        chk("t5_valid", m_valid, 0);
        chk("t5_data", m_data, 0);
        chk("t5_level", fifo_level, 0);
        rx = 1'b1;
        rst_n = 1'b1;
        wait_clk(2 * BITC);
        chk("t5_nopush", fifo_level, 0);
        send_good(8'hC3);
        wait_clk(BITC);
        chk("t5_after", n_pop, exp_pop);

        for (int i = 0; i < 12; i++) begin
            b = 8'($urandom);
            send_good(b);
            wait_clk($urandom_range(0, 200));
        end
        chk("rnd_pops", n_pop, exp_pop);

        m_ready = 1'b0;
        k = $urandom_range(1, DEPTH);
        for (int i = 0; i < k; i++) send_good(8'($urandom));
        wait_clk(BITC);
        chk("burst_level", fifo_level, k);
        m_ready = 1'b1;
        exp_pop += q.size();
        wait_clk(20);
        chk("burst_pops", n_pop, exp_pop);

`ifdef UART_RX_PARITY_EN
        send_good(8'h03);
        wait_clk(BITC);
        chk("par_good", n_pop, exp_pop);
        send(8'h03, 1'b1, 1'b1);
        wait_clk(BITC);
        chk("par_err", n_perr, 1);
        chk("par_nopush", n_pop, exp_pop);
`endif

        chk("end_ferr", n_ferr, 1);
        chk("end_ovr", n_ovr, exp_ovr);
`ifndef UART_RX_PARITY_EN
        chk("end_perr", n_perr, 0);
`endif
        chk("end_q", q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
